// File: rtl/axi_wctrl_pkg.sv
// Shared types and address decode for the AXI write-channel controller.
// Slave selects are one-hot over {S2,S1,S0}; the default (error) slave is all-zero.
package axi_wctrl_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [2:0] SLV_S0  = 3'b001;
  localparam logic [2:0] SLV_S1  = 3'b010;
  localparam logic [2:0] SLV_S2  = 3'b100;
  localparam logic [2:0] SLV_DEF = 3'b000;

  function automatic logic [2:0] decode_slave(
    input logic [15:0] prefix,
    input logic [15:0] p0,
    input logic [15:0] p1,
    input logic [15:0] p2
  );
    if (prefix == p0) return SLV_S0;
    else if (prefix == p1) return SLV_S1;
    else if (prefix == p2) return SLV_S2;
    else return SLV_DEF;
  endfunction

endpackage

// File: rtl/axi_wr_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves away from the master
// reported on last_grant_i whenever update_i is pulsed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] gnt_o
);

  logic favor_m1_q, favor_m1_d;

  always_comb begin
    favor_m1_d = favor_m1_q;
    if (update_i) begin
      if (last_grant_i[0]) favor_m1_d = 1'b1;
      else if (last_grant_i[1]) favor_m1_d = 1'b0;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = favor_m1_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) favor_m1_q <= 1'b0;
    else      favor_m1_q <= favor_m1_d;
  end

endmodule

// File: rtl/axi_wr_ctrl.sv
// AXI write-transaction controller: AW arbitration between two masters, address
// decode to three slaves plus a default slave, W-select hold and B completion.
import axi_wctrl_pkg::*;

module axi_wr_ctrl #(
  parameter logic [15:0] S0_PREFIX = 16'h0000,
  parameter logic [15:0] S1_PREFIX = 16'h0001,
  parameter logic [15:0] S2_PREFIX = 16'h0002,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid_m0_i,
  input  logic [ADDR_W-1:0] awaddr_m0_i,
  output logic              awready_m0_o,
  input  logic              awvalid_m1_i,
  input  logic [ADDR_W-1:0] awaddr_m1_i,
  output logic              awready_m1_o,
  output logic [2:0]        awvalid_s_o,
  input  logic [2:0]        awready_s_i,
  output logic [1:0]        aw_grant_o,
  output logic [2:0]        wsel_o,
  input  logic              wvalid_i,
  input  logic              wready_i,
  input  logic              wlast_i,
  input  logic              bvalid_i,
  input  logic              bready_i,
  output logic              busy_o,
  output logic              decerr_o,
  output logic              timeout_o
);

  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam bit              WD_EN    = (TIMEOUT != 0);

  if ((S0_PREFIX == S1_PREFIX) || (S0_PREFIX == S2_PREFIX) || (S1_PREFIX == S2_PREFIX)) begin : g_prefix_chk
    $error("axi_wr_ctrl: slave address prefixes must be distinct");
  end

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [2:0]      slv_q, slv_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic [1:0]  arb_req, arb_gnt;
  logic        arb_upd;
  logic [15:0] req_prefix;
  logic        in_addr, in_dp, aw_fire, timeout_hit;
  logic        unused_addr_lo;

  assign arb_req    = {awvalid_m1_i, awvalid_m0_i};
  assign req_prefix = arb_gnt[1] ? awaddr_m1_i[31:16] : awaddr_m0_i[31:16];
  // Only the 16-bit prefix participates in decode.
  assign unused_addr_lo = ^{awaddr_m0_i[15:0], awaddr_m1_i[15:0]};

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        (arb_req),
    .update_i     (arb_upd),
    .last_grant_i (grant_q),
    .gnt_o        (arb_gnt)
  );

  assign in_addr     = (state_q == ADDR);
  assign in_dp       = (state_q == DATA) || (state_q == RESP);
  // The default slave accepts the address unconditionally on its single ADDR cycle.
  assign aw_fire     = in_addr && ((slv_q == SLV_DEF) || (|(slv_q & awready_s_i)));
  assign timeout_hit = WD_EN && in_dp && (wdog_q == WD_LIMIT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    slv_d   = slv_q;
    arb_upd = 1'b0;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (|arb_req) begin
          grant_d = arb_gnt;
          slv_d   = decode_slave(req_prefix, S0_PREFIX, S1_PREFIX, S2_PREFIX);
          state_d = ADDR;
        end
      end
      ADDR: if (aw_fire) state_d = DATA;
      DATA: if (wvalid_i && wready_i && wlast_i) state_d = RESP;
      RESP: begin
        if (bvalid_i && bready_i) begin
          state_d = IDLE;
          grant_d = 2'b00;
          slv_d   = SLV_DEF;
          arb_upd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = IDLE;
      grant_d = 2'b00;
      slv_d   = SLV_DEF;
      arb_upd = 1'b1;
    end
    if (state_d != state_q) wdog_d = '0;
    else if (in_dp && (wdog_q != '1)) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      slv_q   <= SLV_DEF;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      slv_q   <= slv_d;
      wdog_q  <= wdog_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_awvalid
    assign awvalid_s_o[gi] = in_addr & slv_q[gi];
  end

  assign awready_m0_o = aw_fire & grant_q[0];
  assign awready_m1_o = aw_fire & grant_q[1];
  assign aw_grant_o   = grant_q;
  assign wsel_o       = in_dp ? slv_q : 3'b000;
  assign busy_o       = (state_q != IDLE);
  assign decerr_o     = in_addr && (slv_q == SLV_DEF);
  assign timeout_o    = timeout_hit;

endmodule
